// File: rtl/fsm_state_recorder_if.sv
// Read-port bundle for the state recorder FIFO: valid/ready handshake plus the record.
interface fsm_state_recorder_if #(
    parameter int TS_W = 12
);
    logic              rd_valid;
    logic              rd_ready;
    logic [9+TS_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/fsm_state_recorder.sv
// Passive observer of the sequence controller: timestamps every state change into a FIFO.
// Optional y1 rising-edge counter is built only when FSM_REC_Y1CNT_EN is defined.
module fsm_state_recorder #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 state_in,
    input  logic                       y1_in,
    input  logic                       clear,
    fsm_state_recorder_if.master       rd,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 y1_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = 9 + TS_W;

    logic [3:0]    prev_q;
    logic [TS_W-1:0] ts_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] mem [DEPTH];

    logic state_event;
    logic full;
    logic pop;
    logic push;

    assign state_event = (state_in != prev_q);
    assign full        = (count == CW'(DEPTH));
    assign pop         = rd.rd_valid && rd.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push        = state_event && (!full || pop);

    assign rd.rd_valid = (count != '0);
    assign rd.rd_data  = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            ts_q     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            prev_q <= state_in;
            if (clear) begin
                ts_q     <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                ts_q <= ts_q + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
                if (state_event && !push) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= {prev_q, state_in, y1_in, ts_q};
    end

`ifdef FSM_REC_Y1CNT_EN
    logic       y1_prev;
    logic [7:0] y1_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1_prev  <= 1'b0;
            y1_cnt_q <= '0;
        end else begin
            y1_prev <= y1_in;
            if (clear)
                y1_cnt_q <= '0;
            else if (y1_in && !y1_prev && y1_cnt_q != 8'hFF)
                y1_cnt_q <= y1_cnt_q + 8'd1;
        end
    end

    assign y1_count = y1_cnt_q;
`else
    assign y1_count = '0;
`endif
endmodule

// File: tb/tb_fsm_state_recorder.sv
// Randomized and directed bench for fsm_state_recorder against a queue-based model.
module tb_fsm_state_recorder;
    localparam int DEPTH = 8;
    localparam int TS_W  = 12;
    localparam int DW    = 9 + TS_W;

    logic        clk;
    logic        rst_n;
    logic [3:0]  state_in;
    logic        y1_in;
    logic        clear;
    logic [$clog2(DEPTH):0] count;
    logic        overflow;
    logic [7:0]  y1_count;

    fsm_state_recorder_if #(.TS_W(TS_W)) rd_if ();

    fsm_state_recorder #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .state_in (state_in),
        .y1_in    (y1_in),
        .clear    (clear),
        .rd       (rd_if),
        .count    (count),
        .overflow (overflow),
        .y1_count (y1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] q[$];
    int            m_ts;
    logic [3:0]    m_prev;
    bit            m_ovf;
    int            m_y1cnt;
    bit            m_y1prev;

`ifdef FSM_REC_Y1CNT_EN
    localparam bit Y1_EN = 1'b1;
`else
    localparam bit Y1_EN = 1'b0;
`endif

    function automatic void chk(input string name, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ts = 0;
        m_prev = 4'd0;
        m_ovf = 1'b0;
        m_y1cnt = 0;
        m_y1prev = 1'b0;
    endfunction

    // One clock edge of the reference behaviour, given the inputs held during that cycle.
    function automatic void model_cycle(input logic [3:0] st, input logic y1, input logic clr, input logic rdy);
        bit ev, do_pop, do_push;
        logic [DW-1:0] rec;
        ev  = (st != m_prev);
        rec = {m_prev, st, y1, 12'(m_ts)};
        if (clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_ts = 0;
            m_y1cnt = 0;
        end else begin
            do_pop  = rdy && (q.size() != 0);
            do_push = ev && (q.size() < DEPTH || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(rec);
            else if (ev) m_ovf = 1'b1;
            m_ts = (m_ts + 1) % (1 << TS_W);
            if (Y1_EN && y1 && !m_y1prev && m_y1cnt < 255) m_y1cnt++;
        end
        m_prev = st;
        m_y1prev = y1;
    endfunction

    function automatic void compare();
        chk("rd_valid", longint'(rd_if.rd_valid), longint'(q.size() != 0));
        if (q.size() != 0) chk("rd_data", longint'(rd_if.rd_data), longint'(q[0]));
        chk("count", longint'(count), longint'(q.size()));
        chk("overflow", longint'(overflow), longint'(m_ovf));
        chk("y1_count", longint'(y1_count), longint'(m_y1cnt));
    endfunction

    task automatic step(input logic [3:0] st, input logic y1, input logic clr, input logic rdy);
        state_in = st;
        y1_in = y1;
        clear = clr;
        rd_if.rd_ready = rdy;
        model_cycle(st, y1, clr, rdy);
        @(negedge clk);
        compare();
    endtask

    logic [DW-1:0] lit;

    initial begin
        rst_n = 1'b0;
        state_in = 4'd0;
        y1_in = 1'b0;
        clear = 1'b0;
        rd_if.rd_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_valid", longint'(rd_if.rd_valid), 0);
        chk("reset_data", longint'(rd_if.rd_data), 0);
        chk("reset_count", longint'(count), 0);
        chk("reset_ovf", longint'(overflow), 0);
        chk("reset_y1", longint'(y1_count), 0);
        rst_n = 1'b1;

        // 0 -> 1 -> 2 -> 3 with no draining
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        step(4'd3, 1'b0, 1'b0, 1'b0);
        chk("seq_count", longint'(count), 3);
        lit = {4'd0, 4'd1, 1'b0, 12'd0};
        chk("seq_rec0", longint'(rd_if.rd_data), longint'(lit));
        step(4'd3, 1'b0, 1'b0, 1'b1);
        lit = {4'd1, 4'd2, 1'b0, 12'd1};
        chk("seq_rec1", longint'(rd_if.rd_data), longint'(lit));
        step(4'd3, 1'b0, 1'b0, 1'b1);
        lit = {4'd2, 4'd3, 1'b0, 12'd2};
        chk("seq_rec2", longint'(rd_if.rd_data), longint'(lit));
        step(4'd3, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) step(4'd3, 1'b0, 1'b0, 1'b0);
        chk("hold_count", longint'(count), 0);
        chk("hold_valid", longint'(rd_if.rd_valid), 0);

        // Nine events into an 8-deep FIFO
        step(4'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step((i % 2 == 0) ? 4'd4 : 4'd3, 1'b0, 1'b0, 1'b0);
        chk("ovf_count", longint'(count), 8);
        chk("ovf_flag", longint'(overflow), 1);
        for (int i = 0; i < 8; i++) step(4'd4, 1'b0, 1'b0, 1'b1);

        // Full FIFO with simultaneous push and pop
        step(4'd4, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'd5 : 4'd4, 1'b1, 1'b0, 1'b0);
        step(4'd12, 1'b0, 1'b0, 1'b1);
        chk("fullpp_count", longint'(count), 8);
        chk("fullpp_ovf", longint'(overflow), 0);
        for (int i = 0; i < 8; i++) step(4'd12, 1'b0, 1'b0, 1'b1);

        // Clear wins over a concurrent event
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        step(4'd3, 1'b0, 1'b0, 1'b0);
        step(4'd7, 1'b0, 1'b1, 1'b1);
        chk("clr_count", longint'(count), 0);
        chk("clr_valid", longint'(rd_if.rd_valid), 0);
        chk("clr_ovf", longint'(overflow), 0);
        step(4'd8, 1'b0, 1'b0, 1'b0);
        chk("clr_ts", longint'(rd_if.rd_data[TS_W-1:0]), 0);
        step(4'd8, 1'b0, 1'b0, 1'b1);

        // 300 y1 rising edges
        step(4'd8, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(4'd8, 1'b1, 1'b0, 1'b1);
            step(4'd8, 1'b0, 1'b0, 1'b1);
        end
        chk("y1_sat", longint'(y1_count), Y1_EN ? 255 : 0);

        // Randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] st;
            if (i == 1500) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("async_valid", longint'(rd_if.rd_valid), 0);
                chk("async_count", longint'(count), 0);
                chk("async_ovf", longint'(overflow), 0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            st = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : state_in;
            step(st, 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
